// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    NOTIFY  = 2'd2,
    FLUSH   = 2'd3
  } rxb_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;
  // Ten bit times of silence at the oversampled rate.
  localparam int RX_TIMEOUT      = 10 * UART_OVERSAMPLE;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the RX buffer controller.
// push/pop arrive already qualified; flush clears pointers and level.
module uart_rx_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage is reset so the head reads 0x00 before the first byte.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// RX buffer controller: queues received bytes, streams them out, and
// raises irq on level threshold, idle timeout or overrun.
module uart_rx_buf_ctrl import uart_pkg::*; #(
  parameter  int DEPTH   = 8,
  parameter  int DATA_W  = UART_DATA_W,
  parameter  int TIMEOUT = RX_TIMEOUT,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [LW-1:0]     thresh,
  output logic [LW-1:0]     level,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic              overrun,
  output logic              irq
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  rxb_state_t    state;
  rxb_state_t    state_nxt;
  logic [TW-1:0] timer;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          accept;
  logic          ovr_set;
  logic          overrun_nxt;
  logic          timeout_hit;
  logic          lvl_hit;

  assign m_valid = !empty && (state != FLUSH);
  assign pop     = m_valid && m_ready && !flush;
  assign accept  = wr_en_i && rx_en && !flush;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push    = accept && (!full || pop);
  assign ovr_set = accept && full && !pop;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .rx_clk  (rx_clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (data_i),
    .rd_data (m_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (push || pop || flush || empty) begin
      timer <= '0;
    end else if (!timeout_hit) begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (timer == T_MAX);
  assign lvl_hit     = (thresh != '0) && (level >= thresh);
  assign overrun_nxt = ovr_set | (overrun & ~clr_overrun);

  // Decisions use the registered level/timer, so alerts lag by one edge.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (!empty) state_nxt = COLLECT;
        COLLECT: begin
          if (empty)                       state_nxt = IDLE;
          else if (lvl_hit || timeout_hit) state_nxt = NOTIFY;
        end
        NOTIFY:  begin
          if (empty)                         state_nxt = IDLE;
          else if (!lvl_hit && !timeout_hit) state_nxt = COLLECT;
        end
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= overrun_nxt;
      irq     <= (state_nxt == NOTIFY) || overrun_nxt;
    end
  end

endmodule

// File: doc/uart_rx_buf_ctrl.md
Name: uart_rx_buf_ctrl

Overview:
Receive-side buffer controller placed between the UART byte receiver and the host/bus side. It captures each byte the receiver delivers with a one-cycle write strobe and queues it in a small FIFO. It presents the bytes on a valid/ready stream and raises an interrupt on level threshold, idle timeout or overrun. It is the scheduling point that decides when the host is told to drain RX data.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
DATA_W, 8, byte width
TIMEOUT, 160, idle rx_clk cycles with data pending before a timeout interrupt (10 bit times at 16x oversampling)

Ports:
rx_clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
rx_en  in  1  capture enable; 0 = incoming bytes dropped silently
wr_en_i  in  1  one-cycle strobe from receiver, byte valid on data_i
data_i  in  DATA_W  received byte
m_data  out  DATA_W  head-of-FIFO byte (first-word-fall-through)
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data this cycle
thresh  in  $clog2(DEPTH)+1  level interrupt threshold; 0 = disabled
level  out  $clog2(DEPTH)+1  current entry count
flush  in  1  synchronous FIFO clear
clr_overrun  in  1  clears sticky overrun flag
overrun  out  1  sticky: byte lost because FIFO full
irq  out  1  interrupt request

Behaviour:
- Reset (async, rst_n=0) sets: pointers=0, level=0, m_valid=0, m_data=0 (storage reset to 0), overrun=0, timer=0, state IDLE, irq=0.
- Push condition is wr_en_i && rx_en && !flush && (!full || pop).
- Pop condition is m_valid && m_ready && !flush.
- Latency: a byte strobed at edge N has m_valid=1, m_data=byte and level incremented after edge N.
- Output order is strictly FIFO. Pointers wrap modulo DEPTH. level is updated by +1, -1 or 0 when push and pop happen together.
- Full with push and pop in the same cycle: both succeed, level unchanged, no overrun.
- Full with push and no pop: byte dropped and overrun<=1.
- Dropped bytes from rx_en=0 or flush do not set overrun.
- overrun is sticky. clr_overrun clears it. If set and clear occur in the same cycle, set wins.
- Timer: reset to 0 on push, pop, flush, or when level=0. Otherwise it increments, saturating at TIMEOUT. timeout_hit = (timer==TIMEOUT).
- FSM, registered state:
  - IDLE: level=0. Goes to COLLECT when level>0.
  - COLLECT: data pending, no alert. Goes to NOTIFY if (thresh!=0 && level>=thresh) || timeout_hit. Goes to IDLE if level=0.
  - NOTIFY: alert outstanding. Goes to IDLE if level=0. Goes to COLLECT if level<thresh (or thresh=0) && !timeout_hit.
  - FLUSH: entered from any state when flush=1 (highest priority). Pointers, level and timer are cleared on that edge. It lasts one cycle, then IDLE. In FLUSH, m_valid=0.
- Transitions are evaluated on registered level/timer values. A threshold-crossing push at edge N therefore produces NOTIFY, and irq=1, after edge N+1.
- irq = (state==NOTIFY) | overrun. It is driven from registers only, so it is glitch-free.
- thresh>DEPTH never fires the level condition. thresh changes take effect on the next evaluation.
- rx_en=0 does not block pops or timer/interrupt operation.
- rst_n asserted mid-operation clears everything immediately. Queued bytes are lost.

Decomposition:
- Shared package uart_pkg holds:
  - rxb_state_t enum {IDLE, COLLECT, NOTIFY, FLUSH}, logic [1:0]
  - UART_DATA_W=8
  - UART_OVERSAMPLE=16
  - default RX_TIMEOUT=160
- One sub-module, uart_rx_fifo, holds the storage array, rd/wr pointers, level, full/empty, and flush/push/pop handling.
- The FSM, timer, overrun flag and irq stay in uart_rx_buf_ctrl.

Test Plan:
- Reset, then release: m_valid=0, level=0, irq=0, overrun=0, m_data=0x00. Assert rst_n low mid-stream at level=3: all outputs return to reset values without a clock edge.
- thresh=0, m_ready=0, push 0xA5 at edge N: m_valid=1, m_data=0xA5, level=1 after N. irq rises after timer saturates at 160 idle cycles. One pop gives level=0, IDLE, irq=0.
- thresh=4, push 0x01..0x04: irq=1 one cycle after level reaches 4. Pop 0x01: irq=0 the cycle after level=3.
- thresh=0, fill 0x01..0x08, then push 0x99 with m_ready=0: level stays 8, overrun=1, irq=1. Drain yields 0x01..0x08 exactly. Pulse clr_overrun: overrun=0.
- Full FIFO, push 0x55 and pop in the same cycle: no overrun, level stays 8, 0x55 emerges last. Simultaneous clr_overrun and an overflow push: overrun stays 1.
- level=5 with flush=1 and a push of 0x77 in the same cycle: FLUSH state, m_valid=0, level=0 next cycle, 0x77 never emitted, overrun unchanged. With rx_en=0, a push is dropped, level unchanged, overrun=0.
